pipe_trace_monitor: RTL
=======================

# pipe_trace_monitor

Synthesizable pipeline trace and performance unit that sits beside the core, next to the write-back stage. It replaces the simulation-only cycle display with hardware that does three things: counts cycles, retirements, taken jumps and per-stage bubbles, and captures retired write-back records into a circular trace buffer. Capture can start on a PC trigger, and the buffer either stops when full or wraps. Host or bench logic drains records through a show-ahead read port.

## Interface
Parameters:
- XLEN, 32, PC/data width
- REG_AW, 5, destination register address width
- NUM_STAGES, 5, number of pipeline stages with a nop flag
- CNT_W, 32, width of every counter
- TRACE_DEPTH, 16, trace entries; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous; zeroes counters, empties buffer, clears overflow, re-enters start state
- stage_nop  in  NUM_STAGES  bit i=1: stage i holds a bubble this cycle
- jump_taken  in  1  ALU-stage jump resolved taken
- wb_nop  in  1  write-back slot is a bubble
- wb_pc  in  XLEN  write-back PC
- wb_w  in  1  write-back writes a register
- wb_rd  in  REG_AW  destination register
- wb_data  in  XLEN  write-back value
- mode_wrap  in  1  0 = stop when full, 1 = overwrite oldest
- trig_en  in  1  arm PC trigger
- trig_pc  in  XLEN  trigger PC
- rd_en  in  1  pop head record; ignored when rd_valid=0
- rd_valid  out  1  buffer non-empty
- rd_pc / rd_w / rd_rd / rd_data  out  XLEN/1/REG_AW/XLEN  head record
- trace_count  out  $clog2(TRACE_DEPTH)+1  occupancy
- overflow  out  1  sticky; a record was dropped or overwritten
- state  out  2  capture state
- cycle_cnt, retire_cnt, jump_cnt  out  CNT_W each
- bubble_cnt  out  NUM_STAGES*CNT_W  stage i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Retire event: wb_nop=0.
- States:
  - ARMED=0: waiting for the trigger.
  - CAPTURE=1: recording.
  - FROZEN=2: stopped after a full-buffer drop.
- Start state after reset or clear: ARMED if trig_en=1, otherwise CAPTURE.
- ARMED → CAPTURE when trig_en=0, or when a retire event has wb_pc==trig_pc. The matching record is itself captured in that cycle.
- CAPTURE, retire event, buffer not full: write {wb_pc, wb_w, wb_rd, wb_data} at the tail.
- CAPTURE, retire event, buffer full, with no pop in the same cycle:
  - mode_wrap=1: overwrite the oldest entry; head and tail both advance; count stays TRACE_DEPTH; overflow set.
  - mode_wrap=0: drop the record; overflow set; state → FROZEN.
- Push and pop in the same cycle: both take effect; count unchanged; no overflow, even when full.
- FROZEN: no captures. Pops still allowed. Only clear or reset leaves FROZEN.
- Counters advance only in CAPTURE and saturate at all-ones:
  - cycle_cnt: +1 every cycle.
  - retire_cnt: +1 per retire event.
  - jump_cnt: +1 per jump_taken.
  - bubble_cnt[i]: +1 per stage_nop[i].
- Pointers wrap modulo TRACE_DEPTH.
- Reset values: every counter 0, trace_count 0, rd_valid 0, rd_* 0, overflow 0. state is ARMED if trig_en=1 during reset, otherwise CAPTURE.
- clear has priority over every event in the same cycle. Reset mid-capture discards buffer contents.

## Timing
- All state updates on posedge clk; reset acts immediately.
- Captured record appears on rd_*/rd_valid one cycle after its retire cycle.
- rd_* is show-ahead: the head is valid combinationally from storage while rd_valid=1. A pop exposes the next entry on the following cycle.
- Counters and trace_count reflect events of cycle N at cycle N+1.
- Trigger compare is combinational on the wb_* inputs. The state change is visible at N+1.

## Structure
- Shared package pipe_trace_pkg:
  - state encodings ARMED/CAPTURE/FROZEN
  - trace record struct {pc, w, rd, data}
  - saturating-increment function
- One sub-module, trace_fifo: a circular buffer parametrised by depth and record width. It has push, pop and wrap-overwrite inputs, and count, full and empty outputs.
- The top level holds the FSM, the trigger and the counters.

## Test plan
- Reset with trig_en=0; retire PCs 0x00, 0x04, 0x08 → state=1, trace_count=3, rd_pc=0x00; pop → rd_pc=0x04.
- trig_en=1, trig_pc=0x10; retire 0x08, 0x0C, 0x10, 0x14 → only 0x10 and 0x14 captured; retire_cnt=2.
- mode_wrap=0, depth 16, 17 retires → trace_count=16, overflow=1, state=2, head is the first record; further retires ignored.
- mode_wrap=1, 20 retires of PC 4·k → trace_count=16, overflow=1, rd_pc=0x10 (k=4).
- Full buffer with push and rd_en in the same cycle → trace_count stays 16, overflow=0.
- stage_nop=5'b00101 for 3 cycles, jump_taken for 2 → bubble_cnt[0]=bubble_cnt[2]=3, jump_cnt=2. Then clear → all counters 0, buffer empty.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace monitor: capture state encoding,
// trace record layout and a saturating counter increment.
package pipe_trace_pkg;

  localparam int TRACE_XLEN   = 32;
  localparam int TRACE_REG_AW = 5;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,  // waiting for the PC trigger
    CAPTURE = 2'd1,  // recording retirements and counting
    FROZEN  = 2'd2   // stopped after a record was dropped on a full buffer
  } state_t;

  // One retired write-back record, for the default XLEN/REG_AW configuration.
  typedef struct packed {
    logic [TRACE_XLEN-1:0]   pc;
    logic                    w;
    logic [TRACE_REG_AW-1:0] rd;
    logic [TRACE_XLEN-1:0]   data;
  } trace_rec_t;

  // Adds en to v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic en,
                                          input int unsigned w);
    logic [63:0] max_v;
    // NOTE: functions and combinational code use blocking '='; only clocked
    // state updates use non-blocking '<='.
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (en && (v != max_v)) ? v + 64'd1 : v;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with show-ahead read.
// Ports:
//   clk, reset (async, active-high), clear (sync empty)
//   push / wr_data : append a record
//   pop            : remove the head record (ignored when empty)
//   wrap           : on a push to a full buffer without a pop, overwrite the
//                    oldest record instead of dropping the new one
//   rd_data        : head record, valid while empty=0
//   count, full, empty : occupancy status
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   wrap,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_pop;
  logic             do_push;
  logic             overwrite;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A push into a full buffer goes through only if a pop frees a slot in the
  // same cycle or the caller allows the oldest record to be overwritten.
  assign do_push   = push && (!full || do_pop || wrap);
  assign overwrite = do_push && full && !do_pop;
  assign rd_data   = mem[head];

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push)             tail <= tail + AW'(1);
      if (do_pop || overwrite) head <= head + AW'(1);
      if (do_push && !do_pop && !overwrite) count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)          count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace and performance monitor beside the write-back stage.
// Counts cycles, retirements, taken jumps and per-stage bubbles while
// capturing, and records retired write-backs into a circular trace buffer.
// Ports:
//   clk, reset (async, active-high), clear (sync restart)
//   stage_nop, jump_taken            : pipeline activity inputs
//   wb_nop, wb_pc, wb_w, wb_rd, wb_data : write-back slot
//   mode_wrap                        : 1 = overwrite oldest when full
//   trig_en, trig_pc                 : PC start trigger
//   rd_en, rd_valid, rd_pc/w/rd/data : show-ahead drain port
//   trace_count, overflow, state     : buffer and capture status
//   cycle_cnt, retire_cnt, jump_cnt, bubble_cnt : saturating counters
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_STAGES  = 5,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [NUM_STAGES-1:0]       stage_nop,
  input  logic                        jump_taken,
  input  logic                        wb_nop,
  input  logic [XLEN-1:0]             wb_pc,
  input  logic                        wb_w,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        mode_wrap,
  input  logic                        trig_en,
  input  logic [XLEN-1:0]             trig_pc,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [XLEN-1:0]             rd_pc,
  output logic                        rd_w,
  output logic [REG_AW-1:0]           rd_rd,
  output logic [XLEN-1:0]             rd_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                        overflow,
  output logic [1:0]                  state,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            jump_cnt,
  output logic [NUM_STAGES*CNT_W-1:0] bubble_cnt
);

  localparam int REC_W = 2*XLEN + 1 + REG_AW;

  // The start state depends on trig_en, which is not a constant, so it is
  // not loaded by the asynchronous reset. Instead start_pending marks the
  // cycle(s) after reset/clear, during which the state is taken from trig_en.
  logic       start_pending;
  state_t     state_q;
  state_t     cur_state;

  logic       retire;
  logic       trig_hit;
  logic       active;
  logic       push_req;
  logic       pop;
  logic       drop;
  logic       overwrite;
  logic       fifo_full;
  logic       fifo_empty;
  logic [REC_W-1:0] head_rec;

  assign cur_state = start_pending ? (trig_en ? ARMED : CAPTURE) : state_q;
  assign state     = cur_state;

  assign retire    = !wb_nop;
  // The triggering retirement is itself captured and counted.
  assign trig_hit  = !trig_en || (retire && (wb_pc == trig_pc));
  assign active    = (cur_state == CAPTURE) || ((cur_state == ARMED) && trig_hit);
  assign push_req  = active && retire;
  assign pop       = rd_en && !fifo_empty;
  assign drop      = push_req && fifo_full && !pop && !mode_wrap;
  assign overwrite = push_req && fifo_full && !pop &&  mode_wrap;

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push_req),
    .pop     (pop),
    .wrap    (mode_wrap),
    .wr_data ({wb_pc, wb_w, wb_rd, wb_data}),
    .rd_data (head_rec),
    .count   (trace_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid = !fifo_empty;
  assign {rd_pc, rd_w, rd_rd, rd_data} = rd_valid ? head_rec : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_pending <= 1'b1;
      state_q       <= CAPTURE;
      overflow      <= 1'b0;
    end else if (clear) begin
      start_pending <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      start_pending <= 1'b0;
      case (cur_state)
        ARMED:   state_q <= drop ? FROZEN : (trig_hit ? CAPTURE : ARMED);
        CAPTURE: state_q <= drop ? FROZEN : CAPTURE;
        default: state_q <= FROZEN;
      endcase
      if (drop || overwrite) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      jump_cnt   <= '0;
      bubble_cnt <= '0;
    end else if (clear) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      jump_cnt   <= '0;
      bubble_cnt <= '0;
    end else begin
      cycle_cnt  <= CNT_W'(sat_inc(64'(cycle_cnt),  active,               CNT_W));
      retire_cnt <= CNT_W'(sat_inc(64'(retire_cnt), active && retire,     CNT_W));
      jump_cnt   <= CNT_W'(sat_inc(64'(jump_cnt),   active && jump_taken, CNT_W));
      for (int i = 0; i < NUM_STAGES; i++) begin
        bubble_cnt[i*CNT_W +: CNT_W] <=
          CNT_W'(sat_inc(64'(bubble_cnt[i*CNT_W +: CNT_W]), active && stage_nop[i], CNT_W));
      end
    end
  end

endmodule
